// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Serial-to-parallel receiver. Collects one bit per valid clock,
//               MSB first, into DATA_W-wide left-aligned words. A word closes
//               after DATA_W bits or early when the valid strobe drops; early
//               words shorter than MIN_LEN are dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer #(
   parameter int DATA_W  = 16,
   parameter int MIN_LEN = 3,
   parameter int MOD_W   = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              ser_data_i,
   input  logic              ser_data_val_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic [MOD_W-1:0]  deser_data_mod_o,
   output logic              deser_data_val_o,
   output logic              frag_err_o,
   output logic              busy_o
);

   // Counter is one bit wider than the mod field so that MIN_LEN comparisons
   // and the last-bit test never alias; it never exceeds DATA_W-1.
   localparam int              c_LAST_I = DATA_W - 1;
   localparam int              c_MIN_I  = MIN_LEN;
   localparam logic [MOD_W:0]  c_LAST   = c_LAST_I[MOD_W:0];
   localparam logic [MOD_W:0]  c_MIN    = c_MIN_I[MOD_W:0];
   localparam logic [DATA_W-1:0] c_MSB  = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W-1:0] r_shift;
   logic [MOD_W:0]    r_cnt;
   logic [DATA_W-1:0] r_data;
   logic [MOD_W-1:0]  r_mod;
   logic              r_val;
   logic              r_frag;
   logic              r_busy;

   logic [DATA_W-1:0] w_bitsel;
   logic [DATA_W-1:0] w_base;
   logic [DATA_W-1:0] w_next;
   logic              w_first;
   logic              w_last;
   logic              w_long_enough;

   // Shift-register next value: write the incoming bit at position
   // DATA_W-1-cnt, clearing all older content when a new word starts.
   always_comb begin
      w_first       = (r_cnt == '0);
      w_last        = (r_cnt == c_LAST);
      w_long_enough = (r_cnt >= c_MIN);
      w_bitsel      = c_MSB >> r_cnt[MOD_W-1:0];
      w_base        = w_first ? '0 : r_shift;
      w_next        = ser_data_i ? (w_base | w_bitsel) : (w_base & ~w_bitsel);
   end

   // Bit capture, word completion, early termination and fragment drop.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_mod   <= '0;
         r_val   <= 1'b0;
         r_frag  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_val  <= 1'b0;
         r_frag <= 1'b0;
         if (ser_data_val_i) begin
            r_shift <= w_next;
            if (w_last) begin
               // Full word: publish it the cycle after its last bit.
               r_data <= w_next;
               r_mod  <= '0;
               r_val  <= 1'b1;
               r_cnt  <= '0;
               r_busy <= 1'b0;
            end else begin
               r_cnt  <= r_cnt + 1'b1;
               r_busy <= 1'b1;
            end
         end else if (!w_first) begin
            // Strobe dropped mid-word: publish a short word or flag a fragment.
            r_cnt  <= '0;
            r_busy <= 1'b0;
            if (w_long_enough) begin
               r_data <= r_shift;
               r_mod  <= r_cnt[MOD_W-1:0];
               r_val  <= 1'b1;
            end else begin
               r_frag <= 1'b1;
            end
         end
      end
   end

   assign deser_data_o     = r_data;
   assign deser_data_mod_o = r_mod;
   assign deser_data_val_o = r_val;
   assign frag_err_o       = r_frag;
   assign busy_o           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer. Bit bursts are turned
//               into expected word/fragment events by a chunking model and
//               compared with events captured from the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

   localparam int DATA_W  = 16;
   localparam int MIN_LEN = 3;
   localparam int MOD_W   = 4;

   typedef struct packed {
      int                kind;   // 1 = data pulse, 2 = fragment error
      logic [DATA_W-1:0] data;
      logic [MOD_W-1:0]  mod;
      int                cyc;
   } ev_t;

   logic              clk_i;
   logic              srst_i;
   logic              ser_data_i;
   logic              ser_data_val_i;
   logic [DATA_W-1:0] deser_data_o;
   logic [MOD_W-1:0]  deser_data_mod_o;
   logic              deser_data_val_o;
   logic              frag_err_o;
   logic              busy_o;

   deserializer #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN)) u_dut (
      .clk_i            (clk_i),
      .srst_i           (srst_i),
      .ser_data_i       (ser_data_i),
      .ser_data_val_i   (ser_data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_data_mod_o (deser_data_mod_o),
      .deser_data_val_o (deser_data_val_o),
      .frag_err_o       (frag_err_o),
      .busy_o           (busy_o)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   overlap_cnt = 0;
   int   last_bit_cyc = 0;
   ev_t  obs_q[$];
   ev_t  exp_q[$];
   bit   burst_q[$];
   logic [DATA_W-1:0] m_data;
   logic [MOD_W-1:0]  m_mod;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // Output monitor: record every pulse with the outputs seen alongside it.
   always @(negedge clk_i) begin
      if (deser_data_val_o) obs_q.push_back('{1, deser_data_o, deser_data_mod_o, cyc});
      if (frag_err_o)       obs_q.push_back('{2, deser_data_o, deser_data_mod_o, cyc});
      if (deser_data_val_o && frag_err_o) overlap_cnt <= overlap_cnt + 1;
   end

   // Reference model: a burst of n bits yields floor(n/DATA_W) full words,
   // then the remainder r (if any) becomes a left-aligned short word with
   // mod=r when r >= MIN_LEN, otherwise a fragment error with outputs held.
   function automatic void model_burst();
      int n   = burst_q.size();
      int pos = 0;
      int rem;
      logic [DATA_W-1:0] w;
      while (n - pos >= DATA_W) begin
         w = '0;
         for (int b = 0; b < DATA_W; b++) w = (w << 1) | DATA_W'(burst_q[pos+b]);
         exp_q.push_back('{1, w, MOD_W'(0), 0});
         m_data = w;
         m_mod  = '0;
         pos += DATA_W;
      end
      rem = n - pos;
      if (rem > 0) begin
         if (rem >= MIN_LEN) begin
            w = '0;
            for (int b = 0; b < rem; b++) w = (w << 1) | DATA_W'(burst_q[pos+b]);
            w = w << (DATA_W - rem);
            exp_q.push_back('{1, w, MOD_W'(rem), 0});
            m_data = w;
            m_mod  = MOD_W'(rem);
         end else begin
            exp_q.push_back('{2, m_data, m_mod, 0});
         end
      end
   endfunction

   task automatic drive(input logic v, input logic d);
      @(posedge clk_i);
      #1;
      ser_data_val_i = v;
      ser_data_i     = v ? d : 1'bx;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w, input int len);
      for (int i = 0; i < len; i++) burst_q.push_back(w[DATA_W-1-i]);
   endtask

   task automatic send_burst(input int gap);
      foreach (burst_q[i]) drive(1'b1, burst_q[i]);
      last_bit_cyc = cyc;
      repeat (gap) drive(1'b0, 1'b0);
      model_burst();
      burst_q.delete();
   endtask

   task automatic flush();
      repeat (3) drive(1'b0, 1'b0);
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      int base;
      srst_i = 1'b1; ser_data_val_i = 1'b0; ser_data_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({deser_data_o, deser_data_mod_o, deser_data_val_o, frag_err_o, busy_o} !== '0) begin
         errors++;
         $display("FAIL reset_state got %h/%0d/%b/%b/%b want all zero",
                  deser_data_o, deser_data_mod_o, deser_data_val_o, frag_err_o, busy_o);
      end
      #2 srst_i = 1'b0;
      // Load a known word so the mid-word reset has something to clear.
      exp_q.delete(); m_data = '0; m_mod = '0;
      push_word(16'h5A5A, DATA_W);
      send_burst(1);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'($urandom_range(0, 1)));
      @(posedge clk_i);
      #3 srst_i = 1'b1;
      #1;
      checks++;
      if ({deser_data_o, deser_data_mod_o, deser_data_val_o, frag_err_o, busy_o} !== '0) begin
         errors++;
         $display("FAIL reset_async got %h/%0d/%b/%b/%b want all zero",
                  deser_data_o, deser_data_mod_o, deser_data_val_o, frag_err_o, busy_o);
      end
      ser_data_val_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #3 srst_i = 1'b0;
      exp_q.delete(); m_data = '0; m_mod = '0;
      base = obs_q.size();
      push_word(16'hA5C3, DATA_W);
      send_burst(1);
      flush();
      checks++;
      if (obs_q.size() - base != 1) begin
         errors++;
         $display("FAIL reset_fresh_count got %0d pulses want 1", obs_q.size() - base);
      end else begin
         checks++;
         if (obs_q[base].kind != 1 || obs_q[base].data !== 16'hA5C3 || obs_q[base].mod !== 4'd0) begin
            errors++;
            $display("FAIL reset_fresh_word got k%0d %h/%0d want k1 a5c3/0",
                     obs_q[base].kind, obs_q[base].data, obs_q[base].mod);
         end
      end
   endtask

   task automatic test_full_word();
      int base = obs_q.size();
      exp_q.delete();
      push_word(16'hBEEF, DATA_W);
      send_burst(1);
      flush();
      checks++;
      if (obs_q.size() - base != 1) begin
         errors++;
         $display("FAIL full_count got %0d want 1", obs_q.size() - base);
      end else begin
         checks++;
         if (obs_q[base].kind != 1 || obs_q[base].data !== 16'hBEEF || obs_q[base].mod !== 4'd0) begin
            errors++;
            $display("FAIL full_word got k%0d %h/%0d want k1 beef/0",
                     obs_q[base].kind, obs_q[base].data, obs_q[base].mod);
         end
         checks++;
         if (obs_q[base].cyc != last_bit_cyc + 1) begin
            errors++;
            $display("FAIL full_latency got cycle %0d want %0d", obs_q[base].cyc, last_bit_cyc + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base = obs_q.size();
      exp_q.delete();
      push_word(16'h1234, DATA_W);
      push_word(16'hFEDC, DATA_W);
      model_burst();
      for (int k = 0; k < 2*DATA_W; k++) begin
         drive(1'b1, burst_q[k]);
         @(negedge clk_i);
         if (k > 0) begin
            checks++;
            if (busy_o !== ((k % DATA_W) != 0)) begin
               errors++;
               $display("FAIL b2b_busy bit %0d got %b want %b", k, busy_o, (k % DATA_W) != 0);
            end
         end
      end
      burst_q.delete();
      flush();
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_count got %0d want %0d", obs_q.size() - base, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data !== exp_q[i].data ||
                obs_q[base+i].mod !== exp_q[i].mod) begin
               errors++;
               $display("FAIL b2b_word%0d got k%0d %h/%0d want k%0d %h/%0d", i,
                        obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].mod,
                        exp_q[i].kind, exp_q[i].data, exp_q[i].mod);
            end
         end
         checks++;
         if (obs_q[base+1].cyc - obs_q[base].cyc != DATA_W) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", obs_q[base+1].cyc - obs_q[base].cyc, DATA_W);
         end
      end
   endtask

   task automatic test_partial();
      int base = obs_q.size();
      exp_q.delete();
      burst_q = '{1, 0, 1, 1, 0};
      send_burst(1);
      flush();
      checks++;
      if (obs_q.size() - base != 1) begin
         errors++;
         $display("FAIL partial_count got %0d want 1", obs_q.size() - base);
      end else begin
         checks++;
         if (obs_q[base].kind != 1 || obs_q[base].data !== 16'hB000 || obs_q[base].mod !== 4'd5) begin
            errors++;
            $display("FAIL partial_word got k%0d %h/%0d want k1 b000/5",
                     obs_q[base].kind, obs_q[base].data, obs_q[base].mod);
         end
      end
   endtask

   task automatic test_fragment();
      int base = obs_q.size();
      exp_q.delete();
      burst_q = '{0, 1};
      send_burst(1);
      flush();
      checks++;
      if (obs_q.size() - base != 1 || obs_q[base].kind != 2) begin
         errors++;
         $display("FAIL frag_event got %0d events want one fragment", obs_q.size() - base);
      end
      checks++;
      if (deser_data_o !== 16'hB000 || deser_data_mod_o !== 4'd5) begin
         errors++;
         $display("FAIL frag_hold got %h/%0d want b000/5", deser_data_o, deser_data_mod_o);
      end
      base = obs_q.size();
      burst_q = '{1, 1, 1};
      send_burst(1);
      flush();
      checks++;
      if (obs_q.size() - base != 1) begin
         errors++;
         $display("FAIL frag_min_count got %0d want 1", obs_q.size() - base);
      end else begin
         checks++;
         if (obs_q[base].kind != 1 || obs_q[base].data !== 16'hE000 || obs_q[base].mod !== 4'd3) begin
            errors++;
            $display("FAIL frag_min_word got k%0d %h/%0d want k1 e000/3",
                     obs_q[base].kind, obs_q[base].data, obs_q[base].mod);
         end
      end
   endtask

   task automatic test_loopback();
      int base = obs_q.size();
      int mods[4] = '{0, 3, 7, 15};
      logic [DATA_W-1:0] w;
      exp_q.delete();
      for (int r = 0; r < 3; r++) begin
         foreach (mods[j]) begin
            w = DATA_W'($urandom);
            push_word(w, (mods[j] == 0) ? DATA_W : mods[j]);
            send_burst(1 + (r % 2));
         end
      end
      flush();
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL loop_count got %0d want %0d", obs_q.size() - base, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data !== exp_q[i].data ||
                obs_q[base+i].mod !== exp_q[i].mod) begin
               errors++;
               $display("FAIL loop_word%0d got k%0d %h/%0d want k%0d %h/%0d", i,
                        obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].mod,
                        exp_q[i].kind, exp_q[i].data, exp_q[i].mod);
            end
         end
      end
   endtask

   task automatic test_random_bursts();
      int base = obs_q.size();
      int len;
      exp_q.delete();
      for (int r = 0; r < 30; r++) begin
         len = $urandom_range(1, 40);
         for (int b = 0; b < len; b++) burst_q.push_back(1'($urandom_range(0, 1)));
         send_burst($urandom_range(1, 3));
      end
      flush();
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count got %0d want %0d", obs_q.size() - base, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data !== exp_q[i].data ||
                obs_q[base+i].mod !== exp_q[i].mod) begin
               errors++;
               $display("FAIL rand_ev%0d got k%0d %h/%0d want k%0d %h/%0d", i,
                        obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].mod,
                        exp_q[i].kind, exp_q[i].data, exp_q[i].mod);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_back_to_back();
      test_partial();
      test_fragment();
      test_loopback();
      test_random_bursts();
      checks++;
      if (overlap_cnt != 0) begin
         errors++;
         $display("FAIL val_frag_overlap got %0d cycles want 0", overlap_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receiver for the serial bit stream produced by the team's serializer: one data bit plus a valid strobe per clock, MSB first.
- Reassembles bits into DATA_W-wide parallel words and reports how many bits each word holds, using the serializer's mod encoding.
- A word ends after DATA_W bits, or early when the valid strobe drops.
- Sits at the receive end of the serial link and feeds a parallel consumer; there is no backpressure.

Parameters:
- DATA_W, 16, parallel word width; power of two, >= 4.
- MIN_LEN, 3, minimum accepted length of a short (partial) word; shorter fragments are dropped and flagged.
- MOD_W, $clog2(DATA_W), width of the bit-count field; derived, do not override.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- srst_i  input  1  reset, asynchronous, active-high.
- ser_data_i  input  1  serial data bit, sampled only when ser_data_val_i=1.
- ser_data_val_i  input  1  serial bit valid.
- deser_data_o  output  DATA_W  reassembled word, left-aligned (first received bit at MSB).
- deser_data_mod_o  output  MOD_W  valid bit count of deser_data_o; 0 means DATA_W bits.
- deser_data_val_o  output  1  one-cycle pulse, word outputs valid.
- frag_err_o  output  1  one-cycle pulse, short fragment dropped.
- busy_o  output  1  partial word in progress (bit counter != 0).

Behaviour:
- Reset is asynchronous, active-high. While srst_i=1: shift register, bit counter, deser_data_o, deser_data_mod_o, deser_data_val_o, frag_err_o and busy_o are all 0.
- Reset mid-word discards the collected bits; no output pulse follows.
- State is implicit: IDLE (cnt==0) and COLLECT (cnt in 1..DATA_W-1). busy_o = (cnt != 0), driven from a register.
- Bit capture, on an edge with ser_data_val_i=1:
  - ser_data_i is written to shift register bit DATA_W-1-cnt.
  - cnt increments by 1.
  - The first bit of a word clears all lower bits of the shift register.
- Full word: the capture edge that takes bit number DATA_W (cnt==DATA_W-1) does all of the following:
  - loads deser_data_o with the complete word;
  - sets deser_data_mod_o=0 and deser_data_val_o=1;
  - resets cnt to 0.
  - Latency: the output is valid in the cycle after the last bit is presented.
- Back-to-back words: a valid bit in the cycle after completion starts the next word. There are no bubbles, so a continuous stream yields one pulse every DATA_W cycles.
- Early end: on an edge with ser_data_val_i=0 and cnt!=0, cnt resets to 0. Then:
  - If cnt >= MIN_LEN: deser_data_o = shift register (unused LSBs = 0), deser_data_mod_o = cnt, deser_data_val_o = 1.
  - If cnt < MIN_LEN: deser_data_o and deser_data_mod_o are unchanged, frag_err_o = 1, deser_data_val_o = 0.
- Idle gap: ser_data_val_i=0 with cnt==0 does nothing.
- deser_data_val_o and frag_err_o are single-cycle pulses and never both 1 in the same cycle.
- deser_data_o and deser_data_mod_o hold their last loaded value between pulses.
- ser_data_i is a don't-care when ser_data_val_i=0; X on it must not propagate.
- cnt is MOD_W+1 bits or compared before increment, so it never wraps past DATA_W-1.

Test Plan:
- Reset: assert srst_i asynchronously between clock edges mid-word (after 5 bits) -> all outputs 0 immediately. After release, a fresh 16-bit stream of 0xA5C3 -> a single pulse with deser_data_o=0xA5C3, mod=0; the 5 stale bits do not appear.
- Full word: 16 valid bits, MSB first, of 0xBEEF -> deser_data_val_o=1 for exactly 1 cycle, the cycle after bit 16; deser_data_o=0xBEEF, deser_data_mod_o=0.
- Back-to-back: 32 continuous valid bits of 0x1234 then 0xFEDC -> pulses 16 cycles apart carrying 0x1234 then 0xFEDC, both with mod=0; busy_o stays 1 except the cycle after each completion.
- Partial word: 5 valid bits 1,0,1,1,0 then valid low -> one pulse, deser_data_o=0xB000, mod=5.
- Fragment: 2 valid bits then valid low -> frag_err_o=1 for 1 cycle, no data pulse, deser_data_o keeps its prior value. Then 3 bits 1,1,1 then valid low -> data pulse 0xE000, mod=3.
- Loopback: serializer driving this block, mod values 0, 3, 7, 15 with random data -> each word reproduced left-aligned with the matching mod; no frag_err_o pulses.
